pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It decides each cycle whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold or are squashed, covering load-use hazards, taken control transfers resolved in EX, and data-cache miss freezes. It also keeps saturating performance counters used by the cache analysis flow.

## Interface
- CNT_W, 32: width of the event counters.
- LAT_W, 16: width of the last-miss-latency register.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id_rs1, id_rs2  in  5 each  source register addresses of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination of the instruction in EX
- ex_lw  in  1  the EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch, jump or jalr
- mem_access  in  1  MEM holds a valid load or store
- dc_hit  in  1  data-cache hit for the current MEM access, same cycle
- dc_fill_done  in  1  one-cycle pulse: miss line filled
- cnt_clear  in  1  synchronous clear of all counters
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register advance enables
- if_id_flush, id_ex_flush  out  1 each  squash to bubble on the next edge
- mem_wb_flush  out  1  insert a bubble into WB
- frozen  out  1  FSM in MEM_WAIT
- cnt_stall, cnt_flush, cnt_loaduse, cnt_miss  out  CNT_W each  event counters
- last_miss_lat  out  LAT_W  cycles spent in the most recent miss

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- RUN to MEM_WAIT: mem_access=1 and dc_hit=0.
- MEM_WAIT to RUN: dc_fill_done=1.
- A miss on the replayed access re-enters MEM_WAIT and counts as a new miss.
- Control outputs are combinational from the state and inputs. Priority is freeze, then redirect, then load-use, then normal.
- Freeze applies when state=MEM_WAIT, or when state=RUN with a miss detected this cycle:
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
  - mem_wb_flush=1.
  - Both upstream flushes are 0.
  - ex_redirect and load-use are ignored, because EX is held and they re-evaluate after the freeze.
- Redirect (ex_redirect=1, not frozen):
  - All enables are 1.
  - if_id_flush=1 and id_ex_flush=1, killing the 2 wrong-path instructions.
  - Any coincident load-use is ignored.
- Load-use:
  - Condition: ex_lw=1, ex_rd≠0, and either (id_use_rs1 and id_rs1=ex_rd) or (id_use_rs2 and id_rs2=ex_rd).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1, others enabled. This is a 1-cycle bubble.
- Normal: all enables are 1 and all flushes are 0.
- A bubble is the ID/EX flush value: rd=0 with EscReg=1, which writes x0 harmlessly. For that reason ex_rd=0 never triggers load-use.
- Counters, all saturating at all-ones:
  - cnt_stall increments every freeze cycle and every load-use cycle.
  - cnt_flush increments per applied redirect.
  - cnt_loaduse increments per applied load-use.
  - cnt_miss increments on each RUN-to-MEM_WAIT transition.
- Latency measurement:
  - An internal LAT_W latency counter loads 1 on entry to MEM_WAIT and increments each MEM_WAIT cycle, saturating.
  - On the dc_fill_done exit it is copied to last_miss_lat.
  - The copied value is the total number of frozen cycles, including the entry cycle.
- cnt_clear zeroes the four counters and last_miss_lat on the next edge. It does not affect the FSM.
- If cnt_clear and an increment occur in the same cycle, the clear wins.

## Timing
- Reset, asynchronous: state=RUN, all counters and last_miss_lat are 0, frozen=0.
- While reset is high, all enables are 1 and all flushes are 0, regardless of the other inputs.
- Control outputs have zero latency from their inputs.
- State, counters and latency register update on the rising clk edge.
- dc_fill_done is ignored in RUN.
- If dc_fill_done arrives in the first MEM_WAIT cycle, the latency is 2.
- A reset asserted mid-miss aborts to RUN immediately.
- last_miss_lat holds until the next completed miss.

## Test plan
- Load-use hazard:
  - Stimulus: ex_lw=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle.
  - Required: pc_en=0, if_id_en=0, id_ex_flush=1; cnt_loaduse=1, cnt_stall=1.
  - Repeat with ex_rd=0: no stall.
- Redirect wins over load-use:
  - Stimulus: ex_redirect=1 together with a load-use match.
  - Required: if_id_flush=1, id_ex_flush=1, pc_en=1; cnt_flush=1, cnt_loaduse=0.
- Miss freeze:
  - Stimulus: mem_access=1, dc_hit=0, then dc_fill_done on the 4th MEM_WAIT cycle.
  - Required: 5 frozen cycles with mem_wb_flush=1; last_miss_lat=5, cnt_miss=1, cnt_stall=5; RUN afterwards.
- Redirect during freeze:
  - Stimulus: ex_redirect=1 held across a miss.
  - Required: no flushes while frozen; both flushes assert in the first RUN cycle.
- Reset mid-miss, then clear:
  - Stimulus: assert reset in MEM_WAIT.
  - Required: frozen drops asynchronously and the counters read 0.
  - Then: cnt_clear together with an increment event leaves the counters at 0.
- Saturation:
  - Stimulus: with CNT_W=4, apply 20 load-use cycles.
  - Required: cnt_loaduse=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline plus saturating hazard/miss counters.
// Control outputs are combinational (zero latency); state, counters and miss latency register on clk.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_lw,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dc_hit,
    input  logic             dc_fill_done,
    input  logic             cnt_clear,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             frozen,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_miss,
    output logic [LAT_W-1:0] last_miss_lat
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_frozen;
    logic [LAT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_cnt_stall;
    logic [CNT_W-1:0] r_cnt_flush;
    logic [CNT_W-1:0] r_cnt_loaduse;
    logic [CNT_W-1:0] r_cnt_miss;
    logic [LAT_W-1:0] r_last_miss_lat;

    logic w_miss_now;
    logic w_freeze;
    logic w_rs1_match;
    logic w_rs2_match;
    logic w_loaduse;
    logic w_redirect_app;
    logic w_loaduse_app;
    logic w_fill_exit;

    function automatic logic [CNT_W-1:0] f_sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LAT_W-1:0] f_sat_lat(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    // A miss freezes the pipe in the very cycle it is seen, before the FSM has moved.
    assign w_miss_now  = (r_state == ST_RUN) && mem_access && !dc_hit;
    assign w_freeze    = (r_state == ST_MEM_WAIT) || w_miss_now;
    assign w_fill_exit = (r_state == ST_MEM_WAIT) && dc_fill_done;

    // ex_rd==0 is excluded: bubbles carry rd=0 and must never stall.
    assign w_rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
    assign w_loaduse   = ex_lw && (ex_rd != 5'd0) && (w_rs1_match || w_rs2_match);

    assign w_redirect_app = ex_redirect && !w_freeze;
    assign w_loaduse_app  = w_loaduse && !w_freeze && !ex_redirect;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (!reset) begin
            if (w_freeze) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_loaduse) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // The latency counter already includes the RUN cycle that detected the miss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_frozen <= 1'b0;
            r_lat    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_miss_now) begin
                        r_state  <= ST_MEM_WAIT;
                        r_frozen <= 1'b1;
                        r_lat    <= LAT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    r_lat <= f_sat_lat(r_lat);
                    if (dc_fill_done) begin
                        r_state  <= ST_RUN;
                        r_frozen <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_frozen <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_stall     <= '0;
            r_cnt_flush     <= '0;
            r_cnt_loaduse   <= '0;
            r_cnt_miss      <= '0;
            r_last_miss_lat <= '0;
        end else if (cnt_clear) begin
            r_cnt_stall     <= '0;
            r_cnt_flush     <= '0;
            r_cnt_loaduse   <= '0;
            r_cnt_miss      <= '0;
            r_last_miss_lat <= '0;
        end else begin
            if (w_freeze || w_loaduse_app)
                r_cnt_stall <= f_sat_cnt(r_cnt_stall);
            if (w_redirect_app)
                r_cnt_flush <= f_sat_cnt(r_cnt_flush);
            if (w_loaduse_app)
                r_cnt_loaduse <= f_sat_cnt(r_cnt_loaduse);
            if (w_miss_now)
                r_cnt_miss <= f_sat_cnt(r_cnt_miss);
            // The exit cycle itself is frozen, so it is added to the running count.
            if (w_fill_exit)
                r_last_miss_lat <= f_sat_lat(r_lat);
        end
    end

    assign frozen        = r_frozen;
    assign cnt_stall     = r_cnt_stall;
    assign cnt_flush     = r_cnt_flush;
    assign cnt_loaduse   = r_cnt_loaduse;
    assign cnt_miss      = r_cnt_miss;
    assign last_miss_lat = r_last_miss_lat;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, built with 4-bit counters to reach saturation quickly.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int LAT_W = 16;

    // Control vector order: pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush
    localparam logic [6:0] C_NORMAL   = 7'b1111_000;
    localparam logic [6:0] C_LOADUSE  = 7'b0011_010;
    localparam logic [6:0] C_REDIRECT = 7'b1111_110;
    localparam logic [6:0] C_FREEZE   = 7'b0000_001;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_lw, ex_redirect;
    logic             mem_access, dc_hit, dc_fill_done, cnt_clear;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, frozen;
    logic [CNT_W-1:0] cnt_stall, cnt_flush, cnt_loaduse, cnt_miss;
    logic [LAT_W-1:0] last_miss_lat;
    logic [6:0]       w_ctrl;

    int checks   = 0;
    int failures = 0;
    int frz_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_lw(ex_lw), .ex_redirect(ex_redirect),
        .mem_access(mem_access), .dc_hit(dc_hit), .dc_fill_done(dc_fill_done),
        .cnt_clear(cnt_clear),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .frozen(frozen),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_loaduse(cnt_loaduse),
        .cnt_miss(cnt_miss), .last_miss_lat(last_miss_lat)
    );

    assign w_ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_lw = 1'b0; ex_redirect = 1'b0;
        mem_access = 1'b0; dc_hit = 1'b0; dc_fill_done = 1'b0; cnt_clear = 1'b0;
    endtask

    task automatic set_loaduse(input logic [4:0] rd, input logic [4:0] rs2);
        ex_lw = 1'b1; ex_rd = rd; id_rs2 = rs2; id_use_rs2 = 1'b1;
        id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        // Hazardous inputs during reset must not reach the outputs.
        set_loaduse(5'd5, 5'd5);
        ex_redirect = 1'b1; mem_access = 1'b1;
        #12;
        check("reset_ctrl", 32'(w_ctrl), 32'(C_NORMAL));
        check("reset_frozen", 32'(frozen), 32'd0);
        check("reset_cnt_stall", 32'(cnt_stall), 32'd0);
        check("reset_last_lat", 32'(last_miss_lat), 32'd0);
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();

        // Load-use on rs2
        set_loaduse(5'd5, 5'd5);
        #2 check("lu_ctrl", 32'(w_ctrl), 32'(C_LOADUSE));
        tick();
        idle_inputs();
        check("lu_cnt_loaduse", 32'(cnt_loaduse), 32'd1);
        check("lu_cnt_stall", 32'(cnt_stall), 32'd1);

        // ex_rd = 0 never stalls
        set_loaduse(5'd0, 5'd0);
        #2 check("lu_x0_ctrl", 32'(w_ctrl), 32'(C_NORMAL));
        tick();
        idle_inputs();
        check("lu_x0_cnt_loaduse", 32'(cnt_loaduse), 32'd1);

        // rs1 address matches but is not used
        set_loaduse(5'd3, 5'd5);
        id_use_rs1 = 1'b0;
        #2 check("lu_unused_rs1_ctrl", 32'(w_ctrl), 32'(C_NORMAL));
        tick();
        idle_inputs();

        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clear_cnt_stall", 32'(cnt_stall), 32'd0);

        // Redirect beats load-use
        set_loaduse(5'd5, 5'd5);
        ex_redirect = 1'b1;
        #2 check("redir_ctrl", 32'(w_ctrl), 32'(C_REDIRECT));
        tick();
        idle_inputs();
        check("redir_cnt_flush", 32'(cnt_flush), 32'd1);
        check("redir_cnt_loaduse", 32'(cnt_loaduse), 32'd0);
        check("redir_cnt_stall", 32'(cnt_stall), 32'd0);

        // Miss with fill on the 4th MEM_WAIT cycle: 5 frozen cycles
        frz_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            mem_access = 1'b1; dc_hit = 1'b0;
            dc_fill_done = (i == 4);
            #2;
            if (w_ctrl == C_FREEZE) frz_cnt++;
            if (i == 0) check("miss_first_frozen", 32'(frozen), 32'd0);
            tick();
            idle_inputs();
        end
        check("miss_frozen_cycles", 32'(frz_cnt), 32'd5);
        check("miss_last_lat", 32'(last_miss_lat), 32'd5);
        check("miss_cnt_miss", 32'(cnt_miss), 32'd1);
        check("miss_cnt_stall", 32'(cnt_stall), 32'd5);
        check("miss_after_frozen", 32'(frozen), 32'd0);
        #2 check("miss_after_ctrl", 32'(w_ctrl), 32'(C_NORMAL));

        // Fill pulse in RUN is ignored
        dc_fill_done = 1'b1;
        tick();
        idle_inputs();
        check("fill_in_run_lat", 32'(last_miss_lat), 32'd5);
        check("fill_in_run_frozen", 32'(frozen), 32'd0);

        // Redirect held across a 3-cycle miss
        frz_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            ex_redirect = 1'b1; mem_access = 1'b1; dc_hit = 1'b0;
            dc_fill_done = (i == 2);
            #2;
            if (w_ctrl == C_FREEZE) frz_cnt++;
            tick();
            idle_inputs();
        end
        check("rdfrz_frozen_cycles", 32'(frz_cnt), 32'd3);
        ex_redirect = 1'b1;
        #2 check("rdfrz_first_run_ctrl", 32'(w_ctrl), 32'(C_REDIRECT));
        tick();
        idle_inputs();
        check("rdfrz_last_lat", 32'(last_miss_lat), 32'd3);
        check("rdfrz_cnt_miss", 32'(cnt_miss), 32'd2);
        check("rdfrz_cnt_flush", 32'(cnt_flush), 32'd2);

        // Fill in first MEM_WAIT cycle, then the replayed access misses again
        mem_access = 1'b1; dc_hit = 1'b0;
        tick();
        dc_fill_done = 1'b1;
        tick();
        dc_fill_done = 1'b0;
        check("lat2_last_lat", 32'(last_miss_lat), 32'd2);
        check("lat2_frozen_run", 32'(frozen), 32'd0);
        #2 check("replay_miss_ctrl", 32'(w_ctrl), 32'(C_FREEZE));
        tick();
        check("replay_frozen", 32'(frozen), 32'd1);
        check("replay_cnt_miss", 32'(cnt_miss), 32'd4);

        // Reset while in MEM_WAIT
        reset = 1'b1;
        #1;
        check("rst_mid_frozen", 32'(frozen), 32'd0);
        check("rst_mid_cnt_miss", 32'(cnt_miss), 32'd0);
        check("rst_mid_last_lat", 32'(last_miss_lat), 32'd0);
        check("rst_mid_ctrl", 32'(w_ctrl), 32'(C_NORMAL));
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();

        // Clear wins over a coincident increment
        set_loaduse(5'd7, 5'd7);
        cnt_clear = 1'b1;
        tick();
        idle_inputs();
        check("clr_win_cnt_loaduse", 32'(cnt_loaduse), 32'd0);
        check("clr_win_cnt_stall", 32'(cnt_stall), 32'd0);

        // Saturation at 4 bits
        for (int i = 0; i < 20; i++) begin
            set_loaduse(5'd9, 5'd9);
            tick();
        end
        idle_inputs();
        check("sat_cnt_loaduse", 32'(cnt_loaduse), 32'd15);
        check("sat_cnt_stall", 32'(cnt_stall), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
